// File: rtl/usb_desc_reader.sv
// usb_desc_reader: GET_DESCRIPTOR data-stage engine; looks up a descriptor in the
// ROM tables and streams it byte by byte as MAXPKT-sized EP0 IN packets.
module usb_desc_reader #(
  parameter int MAXPKT = 64
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        req_valid,
  input  logic [15:0] req_wvalue,
  input  logic [15:0] req_wlength,
  input  logic        hs_mode,
  input  logic        ctrl_abort,
  input  logic        in_req,
  output logic [7:0]  tx_tdata,
  output logic        tx_tvalid,
  input  logic        tx_tready,
  output logic        tx_tlast,
  output logic        tx_zlp,
  output logic        stall,
  output logic        done,
  output logic        busy,
  output logic [15:0] descrom_raddr_o,
  input  logic [7:0]  descrom_rdata_i,
  input  logic [15:0] desc_dev_addr_i,
  input  logic [15:0] desc_dev_len_i,
  input  logic [15:0] desc_qual_addr_i,
  input  logic [15:0] desc_qual_len_i,
  input  logic [15:0] desc_fscfg_addr_i,
  input  logic [15:0] desc_fscfg_len_i,
  input  logic [15:0] desc_hscfg_addr_i,
  input  logic [15:0] desc_hscfg_len_i,
  input  logic [15:0] desc_oscfg_addr_i,
  input  logic [15:0] desc_hidrpt_addr_i,
  input  logic [15:0] desc_hidrpt_len_i,
  input  logic [15:0] desc_bos_addr_i,
  input  logic [15:0] desc_bos_len_i,
  input  logic [15:0] desc_strlang_addr_i,
  input  logic [15:0] desc_strvendor_addr_i,
  input  logic [15:0] desc_strvendor_len_i,
  input  logic [15:0] desc_strproduct_addr_i,
  input  logic [15:0] desc_strproduct_len_i,
  input  logic [15:0] desc_strserial_addr_i,
  input  logic [15:0] desc_strserial_len_i,
  input  logic        desc_have_strings_i
);
  typedef enum logic [2:0] {IDLE, LOOKUP, WAIT_IN, SEND, ZLP} state_t;
  state_t      state_q, state_d;
  logic [15:0] wv_q, wv_d, wl_q, wl_d, ptr_q, ptr_d, rem_q, rem_d;
  logic [6:0]  pkt_q, pkt_d;
  logic        need_zlp_q, need_zlp_d, stall_q, stall_d, done_q, done_d;
  logic [15:0] base, len, rem_sel;
  logic        ok, xfer;
  always_comb begin
    ok   = 1'b1;
    base = '0;
    len  = '0;
    case (wv_q[15:8])
      8'h01: begin base = desc_dev_addr_i; len = desc_dev_len_i; end
      8'h02: begin
        base = hs_mode ? desc_hscfg_addr_i : desc_fscfg_addr_i;
        len  = hs_mode ? desc_hscfg_len_i : desc_fscfg_len_i;
      end
      8'h06: begin base = desc_qual_addr_i; len = desc_qual_len_i; end
      8'h07: begin base = desc_oscfg_addr_i; len = hs_mode ? desc_fscfg_len_i : desc_hscfg_len_i; end
      8'h22: begin base = desc_hidrpt_addr_i; len = desc_hidrpt_len_i; end
      8'h0F: begin base = desc_bos_addr_i; len = desc_bos_len_i; end
      8'h03: begin
        ok   = desc_have_strings_i && wv_q[7:0] <= 8'd3;
        base = wv_q[1:0] == 2'd0 ? desc_strlang_addr_i :
               wv_q[1:0] == 2'd1 ? desc_strvendor_addr_i :
               wv_q[1:0] == 2'd2 ? desc_strproduct_addr_i : desc_strserial_addr_i;
        len  = wv_q[1:0] == 2'd0 ? 16'd4 :
               wv_q[1:0] == 2'd1 ? desc_strvendor_len_i :
               wv_q[1:0] == 2'd2 ? desc_strproduct_len_i : desc_strserial_len_i;
      end
      default: ok = 1'b0;
    endcase
  end
  assign rem_sel = len < wl_q ? len : wl_q;
  assign xfer    = tx_tvalid && tx_tready;
  always_comb begin
    state_d    = state_q;
    wv_d       = wv_q;
    wl_d       = wl_q;
    ptr_d      = ptr_q;
    rem_d      = rem_q;
    pkt_d      = pkt_q;
    need_zlp_d = need_zlp_q;
    stall_d    = 1'b0;
    done_d     = 1'b0;
    if (ctrl_abort) state_d = IDLE;
    else case (state_q)
      IDLE: if (req_valid) begin
        state_d = LOOKUP;
        wv_d    = req_wvalue;
        wl_d    = req_wlength;
      end
      LOOKUP: if (!ok) begin
        stall_d = 1'b1;
        state_d = IDLE;
      end else if (wl_q == 16'd0) begin
        done_d  = 1'b1;
        state_d = IDLE;
      end else begin
        ptr_d      = base;
        rem_d      = rem_sel;
        need_zlp_d = rem_sel < wl_q && (rem_sel & 16'(MAXPKT - 1)) == 16'd0;
        state_d    = WAIT_IN;
      end
      WAIT_IN: if (in_req) begin
        pkt_d   = '0;
        state_d = rem_q != 16'd0 ? SEND : ZLP;
      end
      SEND: if (xfer) begin
        ptr_d = ptr_q + 16'd1;
        rem_d = rem_q - 16'd1;
        pkt_d = pkt_q + 7'd1;
        // rem_q>1 means bytes remain after this handshake
        if (tx_tlast) begin
          state_d = rem_q != 16'd1 || need_zlp_q ? WAIT_IN : IDLE;
          done_d  = rem_q == 16'd1 && !need_zlp_q;
        end
      end
      ZLP: begin
        need_zlp_d = 1'b0;
        done_d     = 1'b1;
        state_d    = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      wv_q       <= '0;
      wl_q       <= '0;
      ptr_q      <= '0;
      rem_q      <= '0;
      pkt_q      <= '0;
      need_zlp_q <= 1'b0;
      stall_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      wv_q       <= wv_d;
      wl_q       <= wl_d;
      ptr_q      <= ptr_d;
      rem_q      <= rem_d;
      pkt_q      <= pkt_d;
      need_zlp_q <= need_zlp_d;
      stall_q    <= stall_d;
      done_q     <= done_d;
    end
  end
  assign tx_tvalid       = state_q == SEND;
  assign tx_tlast        = tx_tvalid && (pkt_q == 7'(MAXPKT - 1) || rem_q == 16'd1);
  assign tx_tdata        = descrom_rdata_i;
  assign tx_zlp          = state_q == ZLP && !ctrl_abort;
  assign stall           = stall_q;
  assign done            = done_q;
  assign busy            = state_q != IDLE;
  assign descrom_raddr_o = ptr_q;
endmodule

// File: tb/tb_usb_desc_reader.sv
// tb_usb_desc_reader: two readers (MAXPKT 64 and 8) over a shared ROM image, checked
// against a transfer-level model of the expected byte stream, packets and pulses.
module tb_usb_desc_reader;
  localparam logic [15:0] DEV_A = 0, DEV_L = 18, FS_A = 20, FS_L = 67, QUAL_A = 88, QUAL_L = 10;
  localparam logic [15:0] HS_A = 98, HS_L = 70, OS_A = 168, HID_A = 170, HID_L = 19;
  localparam logic [15:0] BOS_A = 189, BOS_L = 24, LANG_A = 213, VEN_A = 217, VEN_L = 10;
  localparam logic [15:0] PRD_A = 227, PRD_L = 38, SER_A = 265, SER_L = 20;
  logic clk = 1'b0;
  logic rstn = 1'b1;
  always #5 clk = ~clk;
  logic        sel, req_valid, in_req, hs_mode, ctrl_abort, tx_tready, have_str;
  logic [15:0] req_wvalue, req_wlength;
  logic [7:0]  rom [0:511];
  logic [1:0][7:0]  td;
  logic [1:0][15:0] ra;
  logic [1:0] tv, tl, zl, st, dn, bz;
  logic [7:0]  o_td;
  logic [15:0] o_ra;
  logic [5:0]  stat;
  int nvec = 0;
  int nerr = 0;
  assign o_td = td[sel];
  assign o_ra = ra[sel];
  assign stat = {tv[sel], tl[sel], zl[sel], st[sel], dn[sel], bz[sel]};
  for (genvar g = 0; g < 2; g++) begin : g_dut
    usb_desc_reader #(.MAXPKT(g == 0 ? 64 : 8)) dut (
      .clk(clk), .rstn(rstn),
      .req_valid(req_valid && sel == 1'(g)), .req_wvalue(req_wvalue), .req_wlength(req_wlength),
      .hs_mode(hs_mode), .ctrl_abort(ctrl_abort), .in_req(in_req && sel == 1'(g)),
      .tx_tdata(td[g]), .tx_tvalid(tv[g]), .tx_tready(tx_tready && sel == 1'(g)), .tx_tlast(tl[g]),
      .tx_zlp(zl[g]), .stall(st[g]), .done(dn[g]), .busy(bz[g]),
      .descrom_raddr_o(ra[g]), .descrom_rdata_i(rom[ra[g][8:0]]),
      .desc_dev_addr_i(DEV_A), .desc_dev_len_i(DEV_L),
      .desc_qual_addr_i(QUAL_A), .desc_qual_len_i(QUAL_L),
      .desc_fscfg_addr_i(FS_A), .desc_fscfg_len_i(FS_L),
      .desc_hscfg_addr_i(HS_A), .desc_hscfg_len_i(HS_L),
      .desc_oscfg_addr_i(OS_A),
      .desc_hidrpt_addr_i(HID_A), .desc_hidrpt_len_i(HID_L),
      .desc_bos_addr_i(BOS_A), .desc_bos_len_i(BOS_L),
      .desc_strlang_addr_i(LANG_A),
      .desc_strvendor_addr_i(VEN_A), .desc_strvendor_len_i(VEN_L),
      .desc_strproduct_addr_i(PRD_A), .desc_strproduct_len_i(PRD_L),
      .desc_strserial_addr_i(SER_A), .desc_strserial_len_i(SER_L),
      .desc_have_strings_i(have_str)
    );
  end
  // kind: 0 = stall, 1 = done without data, 2 = n data bytes from base
  function automatic void model(input logic [15:0] wv, wl, input logic hs, hv, input int mp,
                                output int kind, output int base, output int n, output bit zlp);
    int t = int'(wv[15:8]);
    int i = int'(wv[7:0]);
    int len = -1;
    base = 0;
    n = 0;
    zlp = 0;
    if (t == 1) begin base = DEV_A; len = DEV_L; end
    else if (t == 2) begin base = hs ? HS_A : FS_A; len = hs ? HS_L : FS_L; end
    else if (t == 6) begin base = QUAL_A; len = QUAL_L; end
    else if (t == 7) begin base = OS_A; len = hs ? FS_L : HS_L; end
    else if (t == 'h22) begin base = HID_A; len = HID_L; end
    else if (t == 'h0F) begin base = BOS_A; len = BOS_L; end
    else if (t == 3 && hv && i < 4) begin
      base = i == 0 ? LANG_A : i == 1 ? VEN_A : i == 2 ? PRD_A : SER_A;
      len  = i == 0 ? 4 : i == 1 ? VEN_L : i == 2 ? PRD_L : SER_L;
    end
    kind = len < 0 ? 0 : wl == 0 ? 1 : 2;
    if (kind == 2) begin
      n = len < int'(wl) ? len : int'(wl);
      zlp = n < int'(wl) && n % mp == 0;
    end
  endfunction
  task automatic run_xfer(input logic s, input logic [15:0] wv, wl, input logic hs, hv,
                          input bit bp, input int abort_at);
    int kind, base, n, mp, idx, pk, to;
    bit zlp, fin, rdy, exp_last;
    mp = s ? 8 : 64;
    model(wv, wl, hs, hv, mp, kind, base, n, zlp);
    @(negedge clk);
    sel = s; hs_mode = hs; have_str = hv; req_wvalue = wv; req_wlength = wl; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    nvec++;
    if (stat !== (kind == 0 ? 6'b000100 : kind == 1 ? 6'b000010 : 6'b000001)) begin
      nerr++;
      $display("FAIL lookup wv=%h wl=%0d: status %b expected kind %0d", wv, wl, stat, kind);
    end
    if (kind != 2) begin
      @(negedge clk);
      nvec++;
      if (stat !== 6'b000000) begin
        nerr++;
        $display("FAIL pulse_width wv=%h: status %b expected 000000", wv, stat);
      end
      return;
    end
    idx = 0;
    to = 0;
    while (idx < n) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_req = 1'b1;
      @(negedge clk);
      in_req = 1'b0;
      pk = 0;
      fin = 0;
      while (!fin) begin
        exp_last = pk == mp - 1 || idx == n - 1;
        nvec++;
        if (stat !== {1'b1, exp_last, 4'b0001} || o_td !== rom[base + idx] || o_ra !== 16'(base + idx)) begin
          nerr++;
          $display("FAIL byte wv=%h idx=%0d: status %b data %h addr %0d, expected status %b data %h addr %0d",
                   wv, idx, stat, o_td, o_ra, {1'b1, exp_last, 4'b0001}, rom[base + idx], base + idx);
        end
        if (stat[5] !== 1'b1 || ++to > 2000) begin
          ctrl_abort = 1'b1;
          @(negedge clk);
          ctrl_abort = 1'b0;
          return;
        end
        rdy = bp ? $urandom_range(0, 2) != 0 : 1'b1;
        if (idx == abort_at) begin rdy = 1'b1; ctrl_abort = 1'b1; end
        tx_tready = rdy;
        @(negedge clk);
        tx_tready = 1'b0;
        if (ctrl_abort) begin
          ctrl_abort = 1'b0;
          repeat (3) begin
            nvec++;
            if (stat !== 6'b000000) begin
              nerr++;
              $display("FAIL abort wv=%h: status %b expected 000000", wv, stat);
            end
            @(negedge clk);
          end
          return;
        end
        if (rdy) begin idx++; pk++; fin = exp_last; end
      end
      if (idx < n || zlp) begin
        nvec++;
        if (stat !== 6'b000001) begin
          nerr++;
          $display("FAIL between_pkts wv=%h idx=%0d: status %b expected 000001", wv, idx, stat);
        end
      end
    end
    if (zlp) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      in_req = 1'b1;
      @(negedge clk);
      in_req = 1'b0;
      nvec++;
      if (stat !== 6'b001001) begin
        nerr++;
        $display("FAIL zlp wv=%h wl=%0d: status %b expected 001001", wv, wl, stat);
      end
      @(negedge clk);
    end
    nvec++;
    if (stat !== 6'b000010) begin
      nerr++;
      $display("FAIL done wv=%h wl=%0d: status %b expected 000010", wv, wl, stat);
    end
    @(negedge clk);
    nvec++;
    if (stat !== 6'b000000) begin
      nerr++;
      $display("FAIL idle wv=%h: status %b expected 000000", wv, stat);
    end
  endtask
  task automatic test_reset();
    #2 rstn = 1'b0;
    for (int s = 0; s < 2; s++) begin
      @(negedge clk);
      sel = 1'(s);
      #1;
      nvec++;
      if (stat !== 6'b000000 || o_ra !== 16'd0) begin
        nerr++;
        $display("FAIL reset dut%0d: status %b addr %h expected 000000 0000", s, stat, o_ra);
      end
    end
    @(negedge clk);
    rstn = 1'b1;
    sel = 1'b0;
  endtask
  task automatic test_device();      run_xfer(0, 16'h0100, 64, 0, 1, 0, -1); endtask
  task automatic test_fs_config();   run_xfer(0, 16'h0200, 9, 0, 1, 0, -1); endtask
  task automatic test_hs_config();   run_xfer(0, 16'h0200, 16'h00FF, 1, 1, 0, -1); endtask
  task automatic test_zlp();
    run_xfer(1, 16'h0F00, 255, 0, 1, 0, -1);
    run_xfer(1, 16'h0F00, 24, 0, 1, 0, -1);
  endtask
  task automatic test_stall();
    run_xfer(0, 16'h0500, 64, 0, 1, 0, -1);
    run_xfer(0, 16'h0304, 64, 0, 1, 0, -1);
    run_xfer(1, 16'h0301, 64, 0, 0, 0, -1);
  endtask
  task automatic test_string_lang(); run_xfer(0, 16'h0300, 255, 0, 1, 0, -1); endtask
  task automatic test_zero_len();    run_xfer(0, 16'h0100, 0, 0, 1, 0, -1); endtask
  task automatic test_backpressure();
    run_xfer(0, 16'h0302, 255, 0, 1, 1, -1);
    run_xfer(1, 16'h0302, 255, 0, 1, 1, -1);
  endtask
  task automatic test_abort();
    run_xfer(0, 16'h0302, 255, 0, 1, 0, 9);
    run_xfer(0, 16'h0100, 64, 0, 1, 0, -1);
  endtask
  task automatic test_random();
    logic [15:0] wvs [12] = '{16'h0100, 16'h0200, 16'h0600, 16'h0700, 16'h2200, 16'h0F00,
                              16'h0300, 16'h0301, 16'h0302, 16'h0303, 16'h0304, 16'h0900};
    logic [15:0] wls [11] = '{0, 1, 8, 9, 16, 24, 38, 64, 70, 255, 16'hFFFF};
    for (int k = 0; k < 30; k++)
      run_xfer(1'($urandom_range(0, 1)), wvs[$urandom_range(0, 11)],
               $urandom_range(0, 3) == 0 ? 16'($urandom_range(1, 300)) : wls[$urandom_range(0, 10)],
               1'($urandom_range(0, 1)), $urandom_range(0, 4) != 0, 1, -1);
  endtask
  initial begin
    logic [7:0] devb [18] = '{8'h12, 8'h01, 8'h00, 8'h02, 8'h02, 8'h00, 8'h00, 8'h40, 8'h88,
                              8'h88, 8'h77, 8'h77, 8'h00, 8'h02, 8'h01, 8'h02, 8'h03, 8'h01};
    logic [7:0] fsb [9] = '{8'h09, 8'h02, 8'h43, 8'h00, 8'h02, 8'h01, 8'h00, 8'h80, 8'h32};
    logic [7:0] langb [4] = '{8'h04, 8'h03, 8'h09, 8'h04};
    for (int i = 0; i < 512; i++) rom[i] = 8'($urandom);
    for (int i = 0; i < 18; i++) rom[DEV_A + i] = devb[i];
    for (int i = 0; i < 9; i++) rom[FS_A + i] = fsb[i];
    for (int i = 0; i < 4; i++) rom[LANG_A + i] = langb[i];
    sel = 1'b0; req_valid = 1'b0; in_req = 1'b0; hs_mode = 1'b0; ctrl_abort = 1'b0;
    tx_tready = 1'b0; have_str = 1'b1; req_wvalue = '0; req_wlength = '0;
    test_reset();
    test_device();
    test_fs_config();
    test_hs_config();
    test_zlp();
    test_stall();
    test_string_lang();
    test_zero_len();
    test_backpressure();
    test_abort();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/usb_desc_reader.md
Name: usb_desc_reader

Overview:
- Control-endpoint GET_DESCRIPTOR data-stage engine. It sits directly downstream of the descriptor ROM block (usb_desc).
- It decodes wValue into a descriptor base address and length from the ROM's table outputs, then clamps the length to wLength.
- It addresses the ROM byte by byte and streams the bytes to the EP0 IN packetizer. Transfers are split into MAXPKT-byte packets, one packet per IN token, with a trailing ZLP when USB rules require one.

Parameters:
- MAXPKT, 64, EP0 max packet size in bytes; legal values 8, 16, 32, 64.

Ports:
- clk  input  1  clock
- rstn  input  1  asynchronous active-low reset
- req_valid  input  1  1-cycle pulse: decoded GET_DESCRIPTOR setup is ready
- req_wvalue  input  16  setup wValue; [15:8] is the descriptor type, [7:0] is the index
- req_wlength  input  16  setup wLength
- hs_mode  input  1  device is currently operating at high speed
- ctrl_abort  input  1  new SETUP or bus reset; abandons the current transfer
- in_req  input  1  1-cycle pulse: host IN token on EP0, packet slot available
- tx_tdata  output  8  descriptor byte
- tx_tvalid  output  1  byte valid
- tx_tready  input  1  downstream accepts byte
- tx_tlast  output  1  final byte of the current packet
- tx_zlp  output  1  1-cycle pulse: send a zero-length packet
- stall  output  1  1-cycle pulse: unsupported request, STALL EP0
- done  output  1  1-cycle pulse: data stage complete
- busy  output  1  high in every state except IDLE
- descrom_raddr_o  output  16  ROM byte address
- descrom_rdata_i  input  8  ROM data (combinational from descrom_raddr_o)
- desc_*_addr_i / desc_*_len_i  input  16 each  ROM table: dev, qual, fscfg, hscfg, oscfg addr, hidrpt, bos, strlang addr, strvendor, strproduct, strserial
- desc_have_strings_i  input  1  string descriptors present

Behaviour:
- Reset (async, rstn low):
  - state=IDLE.
  - All pulses, tx_tvalid, tx_tlast and busy are 0.
  - descrom_raddr_o=0; pointer, remaining and packet counters are 0.
- States: IDLE, LOOKUP, WAIT_IN, SEND, ZLP.
- IDLE: req_valid moves to LOOKUP. ctrl_abort in the same cycle wins; the FSM stays in IDLE.
- LOOKUP (exactly 1 cycle). Base/length selection by type:
  - 0x01: dev.
  - 0x02: hscfg if hs_mode, else fscfg.
  - 0x06: qual.
  - 0x07: oscfg addr; length = fscfg len if hs_mode, else hscfg len.
  - 0x22: hidrpt.
  - 0x0F: bos.
  - 0x03 (requires desc_have_strings_i): index 0 = strlang with fixed length 4; index 1 = vendor; 2 = product; 3 = serial.
- LOOKUP outcomes:
  - Any other type, string index >3, or a string request with have_strings=0: pulse stall, go to IDLE.
  - req_wlength==0: pulse done, go to IDLE, send no data.
  - Otherwise: ptr=base; rem=min(len, wLength) as a 16-bit unsigned compare; need_zlp = (rem<wLength) && (rem mod MAXPKT==0); go to WAIT_IN.
- WAIT_IN:
  - in_req with rem>0: go to SEND with pkt_cnt=0.
  - in_req with rem==0 (only reachable when need_zlp): go to ZLP.
  - Cycles without in_req are idle.
- SEND:
  - descrom_raddr_o=ptr; tx_tdata=descrom_rdata_i; tx_tvalid=1.
  - tx_tvalid rises in the cycle after in_req.
  - tx_tlast = (pkt_cnt==MAXPKT-1) || (rem==1).
  - tx_tdata, tx_tlast and descrom_raddr_o stay stable while tx_tvalid=1 and tx_tready=0.
  - On a tvalid&&tready handshake: ptr+=1, rem-=1, pkt_cnt+=1.
  - Handshake on a tlast byte: if the new rem>0, go to WAIT_IN. If the new rem==0 and need_zlp, go to WAIT_IN. Otherwise pulse done in the next cycle and go to IDLE.
- ZLP: pulse tx_zlp for 1 cycle, clear need_zlp, pulse done, go to IDLE.
- Address arithmetic: ptr is 16-bit and no bounds check is performed; the table values are trusted. Packets are never longer than MAXPKT.
- ctrl_abort in any state forces IDLE on the next edge:
  - tx_tvalid drops, pending pulses are dropped, done is not pulsed.
  - A byte that handshakes in the abort cycle is discarded downstream.
- req_valid while busy is ignored.

Test Plan:
- Device descriptor: wValue=0x0100, wLength=64, one in_req.
  - Required: 18 bytes 12 01 00 02 02 00 00 40 88 88 77 77 00 02 01 02 03 01.
  - tlast on byte 18 only; done 1 cycle after the final handshake; no zlp.
- FS config: hs_mode=0, wValue=0x0200, wLength=9.
  - Required: exactly 9 bytes 09 02 43 00 02 01 00 80 32 in one packet, tlast on byte 9, need_zlp=0.
- HS config: hs_mode=1, wLength=0xFF, MAXPKT=64.
  - Required: first in_req yields 64 bytes with tlast on byte 64; second in_req yields 6 bytes with tlast.
  - Total 70 bytes read from addresses 98..167; then done.
- ZLP: MAXPKT=8, wValue=0x0F00, wLength=255.
  - Required: three 8-byte packets of BOS (addresses 189..212); 4th in_req gives a tx_zlp pulse, then done.
  - Repeating with wLength=24 gives no ZLP.
- Stall and zero-length cases:
  - wValue=0x0500 -> stall pulse, no tvalid.
  - wValue=0x0304 -> stall.
  - wValue=0x0300 with have_strings=1 -> 04 03 09 04.
  - wLength=0 -> done, no data.
- Backpressure and abort:
  - Random tx_tready during a product-string transfer (38 bytes) -> data and tlast held stable, byte order intact.
  - ctrl_abort at byte 10 -> tvalid low next cycle, no done, busy=0, new req accepted afterwards.
